exec_control_datapath: RTL and testbench
========================================

# exec_control_datapath

Combinational decode-and-execute core of the single-cycle CPU. It bundles the main control unit (opcode to control strobes), the 32-bit ALU with its B-operand select and zero flag, and the ALU-result/memory-data write-back selector. It also holds a one-bit halt latch. The block sits between the register file/sign-extender (operand sources) and the PC logic, data RAM and register write port (strobe and data consumers).

## Interface
- No parameters; data width fixed at 32, opcode width fixed at 6.
- clk  in  1  system clock; halt latch updates on rising edge.
- reset  in  1  asynchronous, active-low; clears halt latch.
- opcode  in  6  instruction[31:26].
- rs_data  in  32  ALU operand A (register read port 1).
- rt_data  in  32  register operand B (register read port 2).
- imm_ext  in  32  sign/zero-extended immediate.
- mem_data  in  32  data RAM read data.
- ext_sel  out  1  1 = sign-extend immediate, 0 = zero-extend.
- pc_wre  out  1  PC write enable; 0 = stall/halt.
- ins_mem_rw  out  1  instruction memory R/W; constant 0 (read).
- reg_out  out  1  destination select; 0 = rt, 1 = rd.
- reg_wre  out  1  register file write enable.
- alu_op  out  3  ALU operation code currently applied.
- alu_src_b  out  1  ALU B select; 0 = rt_data, 1 = imm_ext.
- alu_m2reg  out  1  write-back select; 1 = mem_data.
- pc_src  out  1  1 = take branch offset.
- data_mem_rw  out  1  1 = write data RAM, 0 = read.
- alu_result  out  32  ALU output.
- zero  out  1  1 when alu_result == 0.
- write_data  out  32  register write-back data.

## Operation
ALU (B = alu_src_b ? imm_ext : rt_data), all arithmetic is modulo 2^32 with no overflow flag:
- 000 A+B; 001 A−B; 010 B−A; 011 A|B; 100 A&B; 101 ~A&B; 110 A^B; 111 ~(A^B).

Decode. Every strobe not listed for an opcode is 0. pc_wre is 1 and ins_mem_rw is 0 unless stated otherwise.
- 000000 add: reg_out=1, reg_wre=1, alu_op=000.
- 000001 addi: ext_sel=1, reg_wre=1, alu_src_b=1, alu_op=000.
- 000010 sub: reg_out=1, reg_wre=1, alu_op=001.
- 010000 ori: ext_sel=0, reg_wre=1, alu_src_b=1, alu_op=011.
- 010001 and: reg_out=1, reg_wre=1, alu_op=100.
- 010010 or: reg_out=1, reg_wre=1, alu_op=011.
- 100000 move: reg_out=1, reg_wre=1, alu_op=000 (rt field is $0).
- 100110 sw: ext_sel=1, alu_src_b=1, alu_op=000, data_mem_rw=1.
- 100111 lw: ext_sel=1, reg_wre=1, alu_src_b=1, alu_op=000, alu_m2reg=1.
- 110000 beq: ext_sel=1, alu_op=001, pc_src=zero.
- 111111 halt: pc_wre=0, all other strobes 0.
- Any other opcode: NOP, with pc_wre=1, all other strobes 0, alu_op=000.

Write-back: write_data = alu_m2reg ? mem_data : alu_result.

Halt latch `halted`:
- Set on the rising clk edge when opcode=111111.
- Cleared only by reset.
- While halted=1 (regardless of opcode), pc_wre, reg_wre, data_mem_rw and pc_src are forced to 0.

Reset: while reset=0, pc_wre, reg_wre, data_mem_rw and pc_src are forced to 0. The other outputs follow the decode.

## Timing
- All outputs are combinational from the inputs and the halt latch. Latency is zero cycles within the single-cycle CPU.
- pc_src for beq depends on the zero flag of the same cycle's subtraction (rs − rt).
- Halt takes effect combinationally in the cycle the halt opcode is present. It persists from the next edge onward even if the opcode changes.
- Reset is asynchronous: asserting it mid-cycle immediately clears halted and gates the strobes. Deassertion is sampled with no further latency.
- Reset value of the halt latch is 0.

## Test plan
- add: opcode 000000, A=5, B=3 -> alu_result=8, write_data=8, reg_out=1, reg_wre=1, zero=0. Change to sub -> result=2. Wrap check: A=0, B=1 -> 0xFFFFFFFF.
- ALU op sweep via immediates: ori, A=0x0000F0F0, imm_ext=0x00000F0F -> 0x0000FFFF, ext_sel=0, alu_src_b=1. and, A=0xFF00, B=0x0FF0 -> 0x0F00.
- lw/sw: lw, A=0x10, imm=4, mem_data=0xDEADBEEF -> alu_result=0x14, write_data=0xDEADBEEF, alu_m2reg=1. sw -> data_mem_rw=1, reg_wre=0.
- beq: A=B=7 -> zero=1, pc_src=1. A=7, B=6 -> zero=0, pc_src=0. reg_wre=0 in both cases.
- halt: apply 111111 -> pc_wre=0 immediately. Clock once, apply add -> pc_wre=0, reg_wre=0 while other decode still valid. Assert reset=0 -> halted clears; release -> add gives pc_wre=1.
- Undefined opcode 001111 -> pc_wre=1, reg_wre=0, data_mem_rw=0, alu_op=000.

Source files
------------

// File: rtl/exec_control_datapath.sv
// Decode-and-execute core: main control, 32-bit ALU, write-back mux.
// One-bit halt latch gates the architectural strobes once halt is seen.
module exec_control_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] imm_ext,
  input  logic [31:0] mem_data,
  output logic        ext_sel,
  output logic        pc_wre,
  output logic        ins_mem_rw,
  output logic        reg_out,
  output logic        reg_wre,
  output logic [2:0]  alu_op,
  output logic        alu_src_b,
  output logic        alu_m2reg,
  output logic        pc_src,
  output logic        data_mem_rw,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] write_data
);

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_MOVE = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_RSUB = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_ANDN = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_XNOR = 3'b111;

  typedef struct packed {
    logic       ext_sel;
    logic       pc_wre;
    logic       reg_out;
    logic       reg_wre;
    logic [2:0] alu_op;
    logic       alu_src_b;
    logic       alu_m2reg;
    logic       is_beq;
    logic       data_mem_rw;
  } ctrl_t;

  ctrl_t       ctrl;
  logic        halted;
  logic        gate;
  logic [31:0] op_a;
  logic [31:0] op_b;

  always_comb begin
    ctrl        = '0;
    ctrl.pc_wre = 1'b1;
    unique case (opcode)
      OP_ADD, OP_MOVE: begin
        ctrl.reg_out = 1'b1;
        ctrl.reg_wre = 1'b1;
        ctrl.alu_op  = ALU_ADD;
      end
      OP_ADDI: begin
        ctrl.ext_sel   = 1'b1;
        ctrl.reg_wre   = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_SUB: begin
        ctrl.reg_out = 1'b1;
        ctrl.reg_wre = 1'b1;
        ctrl.alu_op  = ALU_SUB;
      end
      OP_ORI: begin
        ctrl.reg_wre   = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_op    = ALU_OR;
      end
      OP_AND: begin
        ctrl.reg_out = 1'b1;
        ctrl.reg_wre = 1'b1;
        ctrl.alu_op  = ALU_AND;
      end
      OP_OR: begin
        ctrl.reg_out = 1'b1;
        ctrl.reg_wre = 1'b1;
        ctrl.alu_op  = ALU_OR;
      end
      OP_SW: begin
        ctrl.ext_sel     = 1'b1;
        ctrl.alu_src_b   = 1'b1;
        ctrl.alu_op      = ALU_ADD;
        ctrl.data_mem_rw = 1'b1;
      end
      OP_LW: begin
        ctrl.ext_sel   = 1'b1;
        ctrl.reg_wre   = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_m2reg = 1'b1;
      end
      OP_BEQ: begin
        ctrl.ext_sel = 1'b1;
        ctrl.alu_op  = ALU_SUB;
        ctrl.is_beq  = 1'b1;
      end
      OP_HALT: begin
        ctrl.pc_wre = 1'b0;
      end
      default: begin
        ctrl.pc_wre = 1'b1;
      end
    endcase
  end

  assign op_a = rs_data;
  assign op_b = ctrl.alu_src_b ? imm_ext : rt_data;

  always_comb begin
    alu_result = '0;
    unique case (ctrl.alu_op)
      ALU_ADD:  alu_result = op_a + op_b;
      ALU_SUB:  alu_result = op_a - op_b;
      ALU_RSUB: alu_result = op_b - op_a;
      ALU_OR:   alu_result = op_a | op_b;
      ALU_AND:  alu_result = op_a & op_b;
      ALU_ANDN: alu_result = ~op_a & op_b;
      ALU_XOR:  alu_result = op_a ^ op_b;
      ALU_XNOR: alu_result = ~(op_a ^ op_b);
    endcase
  end

  assign zero       = (alu_result == 32'd0);
  assign write_data = ctrl.alu_m2reg ? mem_data : alu_result;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted <= 1'b0;
    end else if (opcode == OP_HALT) begin
      halted <= 1'b1;
    end
  end

  // State-changing strobes are suppressed while halted or held in reset.
  assign gate = halted | ~reset;

  assign ext_sel     = ctrl.ext_sel;
  assign ins_mem_rw  = 1'b0;
  assign reg_out     = ctrl.reg_out;
  assign alu_op      = ctrl.alu_op;
  assign alu_src_b   = ctrl.alu_src_b;
  assign alu_m2reg   = ctrl.alu_m2reg;
  assign pc_wre      = ctrl.pc_wre & ~gate;
  assign reg_wre     = ctrl.reg_wre & ~gate;
  assign data_mem_rw = ctrl.data_mem_rw & ~gate;
  assign pc_src      = ctrl.is_beq & zero & ~gate;

endmodule

// File: tb/tb_exec_control_datapath.sv
// Bench for exec_control_datapath: directed plan steps, then random
// instructions checked against an opcode-table reference model.
module tb_exec_control_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic [31:0] imm_ext = 32'd0;
  logic [31:0] mem_data = 32'd0;
  logic        ext_sel, pc_wre, ins_mem_rw, reg_out, reg_wre;
  logic [2:0]  alu_op;
  logic        alu_src_b, alu_m2reg, pc_src, data_mem_rw;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] write_data;

  int checks = 0;
  int failures = 0;
  bit m_halted = 1'b0;

  exec_control_datapath dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .rs_data(rs_data), .rt_data(rt_data),
    .imm_ext(imm_ext), .mem_data(mem_data),
    .ext_sel(ext_sel), .pc_wre(pc_wre),
    .ins_mem_rw(ins_mem_rw), .reg_out(reg_out),
    .reg_wre(reg_wre), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .alu_m2reg(alu_m2reg),
    .pc_src(pc_src), .data_mem_rw(data_mem_rw),
    .alu_result(alu_result), .zero(zero),
    .write_data(write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: instruction table plus plain arithmetic.
  task automatic check_model();
    bit e_ext, e_pcw, e_rout, e_rw, e_srcb, e_m2r, e_beq, e_dmw;
    bit [2:0] e_op;
    bit [31:0] b, r, wd;
    bit e_zero, e_pcsrc, blocked;
    e_ext = 0; e_pcw = 1; e_rout = 0; e_rw = 0;
    e_srcb = 0; e_m2r = 0; e_beq = 0; e_dmw = 0; e_op = 0;
    case (opcode)
      6'h00, 6'h20: begin e_rout = 1; e_rw = 1; end
      6'h01: begin e_ext = 1; e_rw = 1; e_srcb = 1; end
      6'h02: begin e_rout = 1; e_rw = 1; e_op = 1; end
      6'h10: begin e_rw = 1; e_srcb = 1; e_op = 3; end
      6'h11: begin e_rout = 1; e_rw = 1; e_op = 4; end
      6'h12: begin e_rout = 1; e_rw = 1; e_op = 3; end
      6'h26: begin e_ext = 1; e_srcb = 1; e_dmw = 1; end
      6'h27: begin e_ext = 1; e_rw = 1; e_srcb = 1; e_m2r = 1; end
      6'h30: begin e_ext = 1; e_op = 1; e_beq = 1; end
      6'h3F: e_pcw = 0;
      default: ;
    endcase
    b = e_srcb ? imm_ext : rt_data;
    case (e_op)
      3'd0: r = rs_data + b;
      3'd1: r = rs_data - b;
      3'd2: r = b - rs_data;
      3'd3: r = rs_data | b;
      3'd4: r = rs_data & b;
      3'd5: r = ~rs_data & b;
      3'd6: r = rs_data ^ b;
      default: r = ~(rs_data ^ b);
    endcase
    e_zero = (r == 0);
    wd = e_m2r ? mem_data : r;
    e_pcsrc = e_beq && (rs_data == rt_data);
    blocked = m_halted || !reset;
    if (blocked) begin
      e_pcw = 0; e_rw = 0; e_dmw = 0; e_pcsrc = 0;
    end
    chk("ext_sel", 32'(ext_sel), 32'(e_ext));
    chk("pc_wre", 32'(pc_wre), 32'(e_pcw));
    chk("ins_mem_rw", 32'(ins_mem_rw), 32'd0);
    chk("reg_out", 32'(reg_out), 32'(e_rout));
    chk("reg_wre", 32'(reg_wre), 32'(e_rw));
    chk("alu_op", 32'(alu_op), 32'(e_op));
    chk("alu_src_b", 32'(alu_src_b), 32'(e_srcb));
    chk("alu_m2reg", 32'(alu_m2reg), 32'(e_m2r));
    chk("pc_src", 32'(pc_src), 32'(e_pcsrc));
    chk("data_mem_rw", 32'(data_mem_rw), 32'(e_dmw));
    chk("alu_result", alu_result, r);
    chk("zero", 32'(zero), 32'(e_zero));
    chk("write_data", write_data, wd);
  endtask

  task automatic drive(input logic [5:0] op,
                       input logic [31:0] a,
                       input logic [31:0] bv,
                       input logic [31:0] imm,
                       input logic [31:0] mem,
                       input logic rst);
    reset = rst;
    if (!rst) m_halted = 1'b0;
    opcode = op;
    rs_data = a;
    rt_data = bv;
    imm_ext = imm;
    mem_data = mem;
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset === 1'b1 && opcode == 6'h3F) m_halted = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] ops [13];
    logic [5:0] op;
    logic [31:0] a, bv;
    ops = '{6'h00, 6'h01, 6'h02, 6'h10, 6'h11, 6'h12, 6'h20,
            6'h26, 6'h27, 6'h30, 6'h3F, 6'h0F, 6'h2A};
    #1 reset = 1'b0;
    @(negedge clk);
    drive(6'h00, 32'd5, 32'd3, 32'd0, 32'd0, 1'b0);
    chk("rst_pc_wre", 32'(pc_wre), 32'd0);
    chk("rst_reg_wre", 32'(reg_wre), 32'd0);
    tick();

    drive(6'h00, 32'd5, 32'd3, 32'd0, 32'd0, 1'b1);
    chk("add_res", alu_result, 32'd8);
    chk("add_wd", write_data, 32'd8);
    chk("add_rwe", 32'(reg_wre), 32'd1);
    tick();
    drive(6'h02, 32'd5, 32'd3, 32'd0, 32'd0, 1'b1);
    chk("sub_res", alu_result, 32'd2);
    tick();
    drive(6'h02, 32'd0, 32'd1, 32'd0, 32'd0, 1'b1);
    chk("sub_wrap", alu_result, 32'hFFFF_FFFF);
    tick();
    drive(6'h10, 32'h0000_F0F0, 32'd9, 32'h0000_0F0F, 32'd0, 1'b1);
    chk("ori_res", alu_result, 32'h0000_FFFF);
    chk("ori_ext", 32'(ext_sel), 32'd0);
    tick();
    drive(6'h11, 32'hFF00, 32'h0FF0, 32'd0, 32'd0, 1'b1);
    chk("and_res", alu_result, 32'h0F00);
    tick();
    drive(6'h27, 32'h10, 32'd0, 32'd4, 32'hDEAD_BEEF, 1'b1);
    chk("lw_addr", alu_result, 32'h14);
    chk("lw_wd", write_data, 32'hDEAD_BEEF);
    tick();
    drive(6'h26, 32'h10, 32'd0, 32'd4, 32'hDEAD_BEEF, 1'b1);
    chk("sw_dmw", 32'(data_mem_rw), 32'd1);
    chk("sw_rwe", 32'(reg_wre), 32'd0);
    tick();
    drive(6'h30, 32'd7, 32'd7, 32'd20, 32'd0, 1'b1);
    chk("beq_taken", 32'(pc_src), 32'd1);
    tick();
    drive(6'h30, 32'd7, 32'd6, 32'd20, 32'd0, 1'b1);
    chk("beq_not", 32'(pc_src), 32'd0);
    tick();
    drive(6'h0F, 32'd1, 32'd2, 32'd3, 32'd0, 1'b1);
    chk("undef_pcw", 32'(pc_wre), 32'd1);
    tick();

    drive(6'h3F, 32'd5, 32'd3, 32'd0, 32'd0, 1'b1);
    chk("halt_now", 32'(pc_wre), 32'd0);
    tick();
    drive(6'h00, 32'd5, 32'd3, 32'd0, 32'd0, 1'b1);
    chk("halted_pcw", 32'(pc_wre), 32'd0);
    chk("halted_rwe", 32'(reg_wre), 32'd0);
    chk("halted_res", alu_result, 32'd8);
    tick();
    drive(6'h00, 32'd5, 32'd3, 32'd0, 32'd0, 1'b0);
    tick();
    drive(6'h00, 32'd5, 32'd3, 32'd0, 32'd0, 1'b1);
    chk("unhalt_pcw", 32'(pc_wre), 32'd1);
    tick();

    for (int i = 0; i < 400; i++) begin
      op = ops[$urandom_range(0, 12)];
      if (op == 6'h3F && $urandom_range(0, 2) != 0) op = 6'h00;
      a = $urandom;
      bv = ($urandom_range(0, 3) == 0) ? a : $urandom;
      drive(op, a, bv, $urandom, $urandom,
            ($urandom_range(0, 9) != 0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
